key_event_gen: RTL



---
 rtl/key_event_pkg.sv | 20 ++
 rtl/key_event_if.sv | 23 ++
 rtl/key_event_gen_sync_2ff.sv | 23 ++
 rtl/key_event_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event path: FSM state encoding and the
// default timing constants (50 MHz board clock).
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// Key event bundle: raw button in, clean event strobes out.
// 'release' and 'repeat' are SystemVerilog keywords, so those strobes are
// named release_pulse / repeat_pulse.
interface key_event_if;
    logic key_n;          // raw button, 0 = pressed
    logic held;           // debounced level, 1 = pressed
    logic press;          // one-cycle pulse on accepted press
    logic release_pulse;  // one-cycle pulse on accepted release
    logic repeat_pulse;   // one-cycle auto-repeat pulse
    logic step;           // press | repeat

    // producer: the event generator
    modport master (
        input  key_n,
        output held, press, release_pulse, repeat_pulse, step
    );

    // board / consumer side
    modport slave (
        output key_n,
        input  held, press, release_pulse, repeat_pulse, step
    );
endinterface

// File: rtl/key_event_gen_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// RESET_VAL is the value both flops take in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // two-stage capture; the first stage may go metastable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: raw active-low button -> synchroniser -> debounce FSM ->
// registered press/release pulses, held level and optional auto-repeat.
// Build option: KEY_EVENT_AUTO_REPEAT_EN enables the repeat timer; without it
// repeat_pulse is tied low, step equals press and REPEAT_* are ignored.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic           clk,
    input  logic           reset_n,
    key_event_if.master    ev
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic key_sync;
    logic p;

    state_t          state, state_nxt;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic            held_q, held_nxt;
    logic            press_q, press_nxt;
    logic            rel_q, rel_nxt;
    logic            rpt_q, rpt_nxt;
    logic            step_q;
    logic            rpt_start;   // press accepted: arm the repeat timer

    // Reset value 1 means "released", so a key held through reset is seen
    // as a fresh press once reset lifts.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (ev.key_n),
        .q     (key_sync)
    );

    assign p = ~key_sync;

    // state and debounce counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // next-state, debounce counting and next values of the event outputs
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        held_nxt   = held_q;
        press_nxt  = 1'b0;
        rel_nxt    = 1'b0;
        rpt_start  = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    state_nxt  = PRESS_DB;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_DB: begin
                if (!p) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    rpt_start = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_nxt  = RELEASE_DB;
                    db_cnt_nxt = '0;
                end
            end
            RELEASE_DB: begin
                // a bounce back to pressed keeps held high with no pulse
                if (p) begin
                    state_nxt = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                    held_nxt  = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef KEY_EVENT_AUTO_REPEAT_EN
    localparam int               RPT_W     = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             rpt_hit;

    // Timer only advances in HELD, so release bounces freeze the cadence.
    assign rpt_hit = (state == HELD) && (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));
    assign rpt_nxt = rpt_hit;

    // repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_start) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HELD) begin
            if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign rpt_nxt = 1'b0;
`endif

    // registered outputs; press and repeat come from disjoint states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            held_q  <= held_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
            rpt_q   <= rpt_nxt;
            step_q  <= press_nxt | rpt_nxt;
        end
    end

    assign ev.held          = held_q;
    assign ev.press         = press_q;
    assign ev.release_pulse = rel_q;
    assign ev.repeat_pulse  = rpt_q;
    assign ev.step          = step_q;

endmodule
